// File: rtl/face_scan_core_p.sv
`default_nettype none
// ============================================================================
// face_scan_core_p : multi-scale staged Haar face-window scanner over an
// integral-image tile read through a synchronous RAM port.   Rev 1.0
// ============================================================================
module face_scan_core_p #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 17,
  parameter int TILE_W     = 96,
  parameter int NUM_SCALES = 6,
  parameter int MIN_FW     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        thr_eye_lo,
  input  logic [7:0]        thr_eye_hi,
  input  logic [7:0]        thr_cheek,
  input  logic [7:0]        thr_nose,
  input  logic [7:0]        thr_side,
  input  logic [7:0]        thr_mouth,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              det_valid,
  input  logic              det_ready,
  output logic [15:0]       det_x,
  output logic [15:0]       det_y,
  output logic [2:0]        det_scale,
  output logic              busy,
  output logic              done,
  output logic [31:0]       win_count
);
  localparam int          SW    = DATA_W + 2;
  localparam int          PW    = DATA_W + 10;
  localparam logic [15:0] TMAX  = 16'(TILE_W - 1);
  localparam logic [2:0]  KLAST = 3'(NUM_SCALES - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LATCH   = 4'd1;
  localparam logic [3:0] S_CHECK   = 4'd2;
  localparam logic [3:0] S_FETCH   = 4'd3;
  localparam logic [3:0] S_EVAL    = 4'd4;
  localparam logic [3:0] S_EMIT    = 4'd5;
  localparam logic [3:0] S_ADVANCE = 4'd6;
  localparam logic [3:0] S_FINISH  = 4'd7;

  logic [3:0]           state_q, state_d;
  logic [15:0]          x_q, x_d, y_q, y_d;
  logic [2:0]           k_q, k_d, r_q, r_d;
  logic [1:0]           p_q, p_d;
  logic signed [SW-1:0] acc_q, acc_d;
  logic [31:0]          win_q, win_d;
  logic [7:0]           elo_q, ehi_q, chk_q, nos_q, sid_q, mth_q;

  logic [15:0] fw_tab [8];
  logic [15:0] fh_tab [8];
  logic [15:0] es_tab [8];

  for (genvar g = 0; g < 8; g++) begin : g_scale
    localparam int FW = MIN_FW + g * (MIN_FW / 2);
    assign fw_tab[g] = 16'(FW);
    assign fh_tab[g] = 16'(FW / 6);
    assign es_tab[g] = 16'(FW / 5);
  end

  logic [15:0] w_fw, w_fh, w_es;
  logic        w_scale_ok;
  assign w_fw       = fw_tab[k_q];
  assign w_fh       = fh_tab[k_q];
  assign w_es       = es_tab[k_q];
  assign w_scale_ok = (w_fw <= TMAX) && (w_fh != 16'd0) && ((w_fh << 2) <= TMAX);

  // Rectangle r_q of the cascade: 0 eye, 1 cheek, 2 nose, 3/4 side eyes, 5/6 mouth bands
  logic [15:0] w_x0, w_x1, w_y0, w_y1;
  always_comb begin
    w_x0 = x_q;
    w_x1 = x_q + w_fw;
    w_y0 = y_q;
    w_y1 = y_q + w_fh;
    case (r_q)
      3'd1: begin w_y0 = y_q + w_fh; w_y1 = y_q + (w_fh << 1); end
      3'd2: begin w_x0 = x_q + (w_es << 1); w_x1 = x_q + w_fw - (w_es << 1); end
      3'd3: w_x0 = x_q + w_fw - (w_es << 1);
      3'd4: w_x1 = x_q + (w_es << 1);
      3'd5: begin
        w_x0 = x_q + (w_es << 1);
        w_x1 = x_q + w_fw - (w_es << 1);
        w_y0 = y_q + (w_fh << 1);
        w_y1 = y_q + 16'(3) * w_fh;
      end
      3'd6: begin
        w_x0 = x_q + (w_es << 1);
        w_x1 = x_q + w_fw - (w_es << 1);
        w_y0 = y_q + 16'(3) * w_fh;
        w_y1 = y_q + (w_fh << 2);
      end
      default: ;
    endcase
  end

  logic [15:0] w_cx, w_cy;
  always_comb begin
    case (p_q)
      2'd0:    begin w_cx = w_x1; w_cy = w_y1; end
      2'd1:    begin w_cx = w_x0; w_cy = w_y1; end
      2'd2:    begin w_cx = w_x1; w_cy = w_y0; end
      default: begin w_cx = w_x0; w_cy = w_y0; end
    endcase
  end

  logic [ADDR_W-1:0] w_addr;
  assign w_addr = ADDR_W'(w_cy) * ADDR_W'(TILE_W) + ADDR_W'(w_cx);

  // Mean tests become S versus T*A so no divider is needed
  logic signed [SW-1:0] w_rd, w_sum;
  logic signed [PW-1:0] w_sum_x, w_pa, w_pb;
  logic [31:0]          w_area;
  logic [7:0]           w_ta;
  logic                 w_pass;
  assign w_rd    = $signed({2'b00, mem_rdata});
  assign w_sum   = acc_q + w_rd;
  assign w_sum_x = PW'(w_sum);
  assign w_area  = 32'(w_x1 - w_x0) * 32'(w_y1 - w_y0);
  assign w_pa    = $signed(PW'(w_ta) * PW'(w_area));
  assign w_pb    = $signed(PW'(ehi_q) * PW'(w_area));

  always_comb begin
    case (r_q)
      3'd0:       w_ta = elo_q;
      3'd1:       w_ta = chk_q;
      3'd2:       w_ta = nos_q;
      3'd3, 3'd4: w_ta = sid_q;
      default:    w_ta = mth_q;
    endcase
  end

  always_comb begin
    case (r_q)
      3'd0:       w_pass = (w_sum_x > w_pa) && (w_sum_x < w_pb);
      3'd1, 3'd2: w_pass = w_sum_x > w_pa;
      3'd3, 3'd4: w_pass = w_sum_x < w_pa;
      default:    w_pass = w_sum_x <= w_pa;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    r_d     = r_q;
    p_d     = p_q;
    acc_d   = acc_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LATCH;
      S_LATCH: begin
        win_d   = 32'd0;
        k_d     = 3'd0;
        x_d     = 16'd0;
        y_d     = 16'd0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        r_d = 3'd0;
        p_d = 2'd0;
        if (w_scale_ok)          state_d = S_FETCH;
        else if (k_q == KLAST)   state_d = S_FINISH;
        else                     k_d     = k_q + 3'd1;
      end
      S_FETCH: begin
        p_d = p_q + 2'd1;
        case (p_q)
          2'd0:    acc_d = '0;
          2'd1:    acc_d = acc_q + w_rd;
          default: acc_d = acc_q - w_rd;
        endcase
        if (p_q == 2'd3) state_d = S_EVAL;
      end
      S_EVAL: begin
        p_d = 2'd0;
        if (w_pass) begin
          if (r_q >= 3'd5) state_d = S_EMIT;
          else begin
            r_d     = r_q + 3'd1;
            state_d = S_FETCH;
          end
        end else if (r_q == 3'd5) begin
          r_d     = 3'd6;
          state_d = S_FETCH;
        end else begin
          state_d = S_ADVANCE;
        end
      end
      S_EMIT: if (det_ready) state_d = S_ADVANCE;
      S_ADVANCE: begin
        win_d   = win_q + 32'd1;
        r_d     = 3'd0;
        p_d     = 2'd0;
        state_d = S_FETCH;
        if (x_q + w_fw == TMAX) begin
          x_d = 16'd0;
          y_d = y_q + 16'd1;
          if (y_q + 16'd1 + (w_fh << 2) > TMAX) begin
            y_d = 16'd0;
            if (k_q == KLAST) state_d = S_FINISH;
            else begin
              k_d     = k_q + 3'd1;
              state_d = S_CHECK;
            end
          end
        end else begin
          x_d = x_q + 16'd1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      k_q     <= 3'd0;
      r_q     <= 3'd0;
      p_q     <= 2'd0;
      acc_q   <= '0;
      win_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      r_q     <= r_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      elo_q <= 8'd0; ehi_q <= 8'd0; chk_q <= 8'd0;
      nos_q <= 8'd0; sid_q <= 8'd0; mth_q <= 8'd0;
    end else if (state_q == S_LATCH) begin
      elo_q <= thr_eye_lo; ehi_q <= thr_eye_hi; chk_q <= thr_cheek;
      nos_q <= thr_nose;   sid_q <= thr_side;   mth_q <= thr_mouth;
    end
  end

  assign mem_rd    = (state_q == S_FETCH);
  assign mem_addr  = mem_rd ? w_addr : '0;
  assign det_valid = (state_q == S_EMIT);
  assign det_x     = x_q;
  assign det_y     = y_q;
  assign det_scale = k_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done      = (state_q == S_FINISH);
  assign win_count = win_q;

endmodule
`default_nettype wire

// File: tb/tb_face_scan_core_p.sv
`default_nettype none
// ============================================================================
// tb_face_scan_core_p : directed checks of face_scan_core_p on a 24x24 tile
// Rev 1.0
// ============================================================================
module tb_face_scan_core_p;
  localparam int TW = 24;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  thr_eye_lo = 8'd110, thr_eye_hi = 8'd212, thr_cheek = 8'd237;
  logic [7:0]  thr_nose = 8'd237, thr_side = 8'd196, thr_mouth = 8'd206;
  logic        mem_rd;
  logic [16:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic        det_valid;
  logic        det_ready = 1'b1;
  logic [15:0] det_x, det_y;
  logic [2:0]  det_scale;
  logic        busy, done;
  logic [31:0] win_count;

  always #5 clk = ~clk;

  face_scan_core_p #(
    .DATA_W(32), .ADDR_W(17), .TILE_W(TW), .NUM_SCALES(2), .MIN_FW(12)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .thr_eye_lo(thr_eye_lo), .thr_eye_hi(thr_eye_hi), .thr_cheek(thr_cheek),
    .thr_nose(thr_nose), .thr_side(thr_side), .thr_mouth(thr_mouth),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .det_valid(det_valid), .det_ready(det_ready),
    .det_x(det_x), .det_y(det_y), .det_scale(det_scale),
    .busy(busy), .done(done), .win_count(win_count)
  );

  logic [31:0] ram [TW*TW];
  int          pix [TW][TW];
  int          dd  [TW][TW];

  always @(posedge clk)
    if (mem_rd) mem_rdata <= (int'(mem_addr) < TW*TW) ? ram[int'(mem_addr)] : 32'd0;

  int          rec_cnt = 0, done_cnt = 0;
  logic [15:0] last_x = 16'd0, last_y = 16'd0;
  logic [2:0]  last_k = 3'd0;
  always @(posedge clk) begin
    if (det_valid && det_ready) begin
      rec_cnt <= rec_cnt + 1;
      last_x  <= det_x;
      last_y  <= det_y;
      last_k  <= det_scale;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: flat 255; 1: face, mouth rows 11-12; 2: mouth rows 13-14; 3: mouth rows 17-18
  task automatic load_image(input int mode);
    int mr;
    mr = (mode == 2) ? 13 : (mode == 3) ? 17 : 11;
    for (int y = 0; y < TW; y++)
      for (int x = 0; x < TW; x++) pix[y][x] = 255;
    if (mode != 0) begin
      for (int x = 5; x <= 16; x++) begin
        pix[7][x] = 150; pix[8][x] = 150;
        pix[9][x] = 250; pix[10][x] = 250;
      end
      for (int x = 9; x <= 12; x++) begin
        pix[7][x] = 250; pix[8][x] = 250;
        pix[mr][x] = 100; pix[mr+1][x] = 100;
      end
    end
    for (int y = 0; y < TW; y++)
      for (int x = 0; x < TW; x++) begin
        if (x == 0 || y == 0) dd[y][x] = 0;
        else dd[y][x] = pix[y-1][x-1] + dd[y-1][x] + dd[y][x-1] - dd[y-1][x-1];
        ram[y*TW + x] = 32'(dd[y][x]);
      end
  endtask

  task automatic run_to_done(input bit repulse, output bit seen);
    int n;
    n = 0;
    seen = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!seen && n < 6000) begin
      start = (repulse && n == 40);
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic full_scan(input string pre, input int exp_rec, input bit repulse);
    int r0, d0;
    bit seen;
    r0 = rec_cnt;
    d0 = done_cnt;
    run_to_done(repulse, seen);
    chk({pre, "_done_seen"}, seen, 1);
    @(negedge clk);
    chk({pre, "_busy_after"}, busy, 0);
    chk({pre, "_done_width"}, done, 0);
    chk({pre, "_win_count"}, win_count, 264);
    chk({pre, "_records"}, rec_cnt - r0, exp_rec);
    chk({pre, "_done_pulses"}, done_cnt - d0, 1);
    if (exp_rec == 1) begin
      chk({pre, "_x"}, last_x, 5);
      chk({pre, "_y"}, last_y, 7);
      chk({pre, "_k"}, last_k, 0);
    end
  endtask

  task automatic wait_valid(output bit seen);
    int n;
    n = 0;
    while (!det_valid && n < 6000) begin
      @(negedge clk);
      n++;
    end
    seen = det_valid;
  endtask

  initial begin
    bit          seen, fld_ok, rd_ok, wc_ok;
    int          r0, d0;
    logic [31:0] wc;

    load_image(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", det_valid, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_win", win_count, 0);
    reset = 1'b0;
    @(negedge clk);

    full_scan("flat", 0, 1'b0);
    load_image(1);
    full_scan("face", 1, 1'b1);
    load_image(2);
    full_scan("retry", 1, 1'b0);
    load_image(3);
    full_scan("nomouth", 0, 1'b0);

    // Backpressure on the single detection
    load_image(1);
    det_ready = 1'b0;
    r0 = rec_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(seen);
    chk("stall_valid_seen", seen, 1);
    wc = win_count;
    chk("stall_win_at_det", wc, 89);
    fld_ok = 1'b1; rd_ok = 1'b1; wc_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!det_valid || det_x != 16'd5 || det_y != 16'd7 || det_scale != 3'd0) fld_ok = 1'b0;
      if (mem_rd) rd_ok = 1'b0;
      if (win_count != wc) wc_ok = 1'b0;
    end
    chk("stall_fields", fld_ok, 1);
    chk("stall_mem_rd", rd_ok, 1);
    chk("stall_win", wc_ok, 1);
    det_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("stall_done_seen", seen, 1);
    @(negedge clk);
    chk("stall_records", rec_cnt - r0, 1);
    chk("stall_win_final", win_count, 264);

    // Reset while a record is pending
    det_ready = 1'b0;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(seen);
    chk("abort_valid_seen", seen, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", det_valid, 0);
    chk("abort_mem_rd", mem_rd, 0);
    chk("abort_done", done, 0);
    chk("abort_win", win_count, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", busy, 0);
    det_ready = 1'b1;
    full_scan("rescan", 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
